// File: rtl/shared_divider_if.sv
// Client/divider bundle: operands and start toward the divider, results and status back.
// Masters watch busy before pulsing start; one division in flight at a time.
interface shared_divider_if #(
  parameter int WIDTH_div = 16
);
  logic                   start;
  logic [2*WIDTH_div-1:0] dividerbus;
  logic [WIDTH_div-1:0]   dividerres;
  logic [WIDTH_div-1:0]   remainder;
  logic                   busy;
  logic                   ready;
  logic                   div0;

  modport master (
    output start, dividerbus,
    input  dividerres, remainder, busy, ready, div0
  );

  modport slave (
    input  start, dividerbus,
    output dividerres, remainder, busy, ready, div0
  );
endinterface

// File: rtl/shared_divider.sv
// Unsigned restoring divider, WIDTH_div iterations; ready pulses WIDTH_div+1 cycles after accept.
// start is ignored while busy; a start during the ready cycle is accepted back-to-back.
module shared_divider #(
  parameter int WIDTH_div = 16
) (
  input  logic             clk,
  input  logic             r,
  shared_divider_if.slave  bus
);
  localparam int W  = WIDTH_div;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  p_reg;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  d_reg;
  logic [CW-1:0] cnt;
  logic [W-1:0]  res_q, rem_q;
  logic          div0_q;
  logic          busy_o, ready_o;
  logic          accept, last_iter;
  logic [W:0]    p_shift;
  logic [W-1:0]  p_sub, p_nxt, q_nxt;
  logic          ge;

  assign accept    = bus.start && !busy_o;
  assign last_iter = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk or negedge r) begin
    if (!r) state <= IDLE;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state == RUN);
    ready_o = (state == DONE);
  end

  // The restored remainder is always below the divisor, so W bits hold it;
  // only the shifted trial value needs the extra bit for the compare.
  always_comb begin
    p_shift = {p_reg, q_reg[W-1]};
    ge      = (p_shift >= {1'b0, d_reg});
    p_sub   = p_shift[W-1:0] - d_reg;
    p_nxt   = ge ? p_sub : p_shift[W-1:0];
    q_nxt   = {q_reg[W-2:0], ge};
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      p_reg  <= '0;
      q_reg  <= '0;
      d_reg  <= '0;
      cnt    <= '0;
      res_q  <= '0;
      rem_q  <= '0;
      div0_q <= 1'b0;
    end else if (accept) begin
      q_reg <= bus.dividerbus[2*W-1:W];
      d_reg <= bus.dividerbus[W-1:0];
      p_reg <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      p_reg <= p_nxt;
      q_reg <= q_nxt;
      cnt   <= cnt + 1'b1;
      // Results land with the final iteration so they are valid during the ready cycle.
      if (last_iter) begin
        res_q  <= q_nxt;
        rem_q  <= p_nxt;
        div0_q <= (d_reg == '0);
      end
    end
  end

  assign bus.dividerres = res_q;
  assign bus.remainder  = rem_q;
  assign bus.div0       = div0_q;
  assign bus.busy       = busy_o;
  assign bus.ready      = ready_o;
endmodule

// File: tb/tb_shared_divider.sv
// Directed bench for shared_divider: scoreboard of expected results checked on each ready pulse.
module tb_shared_divider;
  localparam int W = 16;

  logic clk = 1'b0;
  logic r;
  always #5 clk = ~clk;

  shared_divider_if #(.WIDTH_div(W)) dif();
  shared_divider #(.WIDTH_div(W)) dut (.clk(clk), .r(r), .bus(dif));

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] rm;
    logic         d0;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input int c);
    exp_t e;
    e.q   = (dvs == '0) ? '1 : dvd / dvs;
    e.rm  = (dvs == '0) ? dvd : dvd % dvs;
    e.d0  = (dvs == '0);
    e.cyc = c;
    return e;
  endfunction

  // Scoreboard: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (r === 1'b1 && dif.ready === 1'b1) begin
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_ready: observed ready=1 at cycle %0d expected no pending result", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("quotient",  32'(dif.dividerres), 32'(e.q));
        chk("remainder", 32'(dif.remainder),  32'(e.rm));
        chk("div0",      32'(dif.div0),       32'(e.d0));
        chk("latency",   32'(cyc),            32'(e.cyc));
      end
    end
  end

  task automatic drain();
    #1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    @(negedge clk);
    dif.dividerbus = {dvd, dvs};
    dif.start      = 1'b1;
    sb.push_back(mk(dvd, dvs, cyc + 1 + W));
    @(negedge clk);
    dif.start      = 1'b0;
    dif.dividerbus = $urandom;
    for (int i = 0; i < W; i++) begin
      chk("busy_run", 32'(dif.busy), 32'd1);
      @(negedge clk);
    end
    chk("busy_done", 32'(dif.busy), 32'd0);
    drain();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    r              = 1'b0;
    dif.start      = 1'b0;
    dif.dividerbus = '0;
    repeat (2) @(negedge clk);
    chk("rst_res",   32'(dif.dividerres), 32'd0);
    chk("rst_rem",   32'(dif.remainder),  32'd0);
    chk("rst_busy",  32'(dif.busy),       32'd0);
    chk("rst_ready", 32'(dif.ready),      32'd0);
    chk("rst_div0",  32'(dif.div0),       32'd0);
    r = 1'b1;
    @(negedge clk);

    run_div(16'd57600, 16'd25);
    run_div(16'd1000,  16'd7);
    run_div(16'd65535, 16'd1);

    // Start pulsed mid-run with different operands must be ignored.
    @(negedge clk);
    dif.dividerbus = {16'd57600, 16'd25};
    dif.start      = 1'b1;
    sb.push_back(mk(16'd57600, 16'd25, cyc + 1 + W));
    @(negedge clk);
    dif.start = 1'b0;
    repeat (4) @(negedge clk);
    dif.dividerbus = {16'd9, 16'd3};
    dif.start      = 1'b1;
    @(negedge clk);
    dif.start      = 1'b0;
    dif.dividerbus = '0;
    drain();
    repeat (20) @(negedge clk);
    chk("ignored_busy", 32'(dif.busy), 32'd0);

    // start held through ready: second division accepted in the DONE cycle.
    @(negedge clk);
    dif.dividerbus = {16'd1000, 16'd7};
    dif.start      = 1'b1;
    k = cyc + 1;
    sb.push_back(mk(16'd1000, 16'd7, k + W));
    @(negedge clk);
    dif.dividerbus = {16'd65535, 16'd3};
    sb.push_back(mk(16'd65535, 16'd3, k + 2 * W + 1));
    repeat (W + 1) @(negedge clk);
    chk("b2b_busy", 32'(dif.busy), 32'd1);
    dif.start = 1'b0;
    drain();

    run_div(16'd5,    16'd9);
    run_div(16'd1234, 16'd0);

    // Reset in the middle of a division discards it.
    @(negedge clk);
    dif.dividerbus = {16'd57600, 16'd25};
    dif.start      = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (7) @(negedge clk);
    r = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(dif.busy),       32'd0);
    chk("mid_rst_ready", 32'(dif.ready),      32'd0);
    chk("mid_rst_res",   32'(dif.dividerres), 32'd0);
    chk("mid_rst_rem",   32'(dif.remainder),  32'd0);
    chk("mid_rst_div0",  32'(dif.div0),       32'd0);
    repeat (3) @(negedge clk);
    r = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(dif.ready), 32'd0);
    end

    run_div(16'd1000,  16'd7);
    run_div(16'd60000, 16'd300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
